// File: rtl/mips_pkg.sv
// Shared pipeline definitions: default bus widths, word-offset constant and
// the store-buffer drain FSM encoding.
package mips_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  // Byte-offset bits below a word; ignored for word-only accesses.
  localparam int unsigned WORD_LSB = 2;

  typedef enum logic {
    SB_IDLE,
    SB_BUSY
  } sb_state_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-buffer load forwarding: DEPTH-way word-address compare with the
// youngest matching entry (closest behind the write pointer) winning.
module sb_fwd_match
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WA_W   = DEF_ADDR_W - WORD_LSB,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0][WA_W-1:0]   addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
  input  logic [PTR_W-1:0]             wr_ptr_i,
  input  logic [WA_W-1:0]              ld_waddr_i,
  output logic                         match_o,
  output logic [DATA_W-1:0]            data_o
);

  logic [PTR_W-1:0] idx;

  // Walk entries oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    match_o = 1'b0;
    data_o  = '0;
    idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      // Age DEPTH-k behind the write pointer; modulo wrap comes from PTR_W.
      idx = wr_ptr_i - PTR_W'(DEPTH - k);
      if (valid_i[idx] && (addr_i[idx] == ld_waddr_i)) begin
        match_o = 1'b1;
        data_o  = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the M stage and a handshaked data memory.
// Stores enter in one cycle, drain to memory in program order, and loads
// see the youngest buffered data for their word address.
module store_buffer
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid_i,
  input  logic [ADDR_W-1:0]        st_addr_i,
  input  logic [DATA_W-1:0]        st_data_i,
  output logic                     st_ready_o,
  input  logic                     ld_valid_i,
  input  logic [ADDR_W-1:0]        ld_addr_i,
  output logic                     ld_hit_o,
  output logic [DATA_W-1:0]        ld_data_o,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  input  logic                     mem_ack_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WA_W  = ADDR_W - WORD_LSB;

  logic [DEPTH-1:0][WA_W-1:0]   addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  sb_state_t                    state_q, state_d;

  logic push, pop;
  logic fwd_match;
  logic [DATA_W-1:0] fwd_data;

  // Byte-offset bits carry no information for word accesses.
  logic unused_offsets;
  assign unused_offsets = ^{st_addr_i[WORD_LSB-1:0], ld_addr_i[WORD_LSB-1:0]};

  assign st_ready_o = (count_q != CNT_W'(DEPTH));
  assign count_o    = count_q;
  assign empty_o    = (count_q == '0);

  // Pop only while a request is actually presented; a stray ack in IDLE is ignored.
  assign push = st_valid_i && st_ready_o;
  assign pop  = (state_q == SB_BUSY) && mem_ack_i;

  // Next-state for pointers, occupancy count and per-entry valid bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers, count, valid bits; all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Entry payload; never read unless its valid bit is set, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= st_addr_i[ADDR_W-1:WORD_LSB];
      data_q[wr_ptr_q] <= st_data_i;
    end
  end

  // Drain FSM next-state: BUSY whenever the buffer will hold at least one entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_IDLE: if (count_d != '0) state_d = SB_BUSY;
      SB_BUSY: if (count_d == '0) state_d = SB_IDLE;
      default: state_d = SB_IDLE;
    endcase
  end

  // Drain FSM state register; reset withdraws any in-flight request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory-side outputs come straight from the head entry, zeroed when idle.
  always_comb begin
    mem_req_o   = (state_q == SB_BUSY);
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      mem_addr_o  = {addr_q[rd_ptr_q], {WORD_LSB{1'b0}}};
      mem_wdata_o = data_q[rd_ptr_q];
    end
  end

  sb_fwd_match #(
    .DEPTH  (DEPTH),
    .WA_W   (WA_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_fwd (
    .valid_i    (valid_q),
    .addr_i     (addr_q),
    .data_i     (data_q),
    .wr_ptr_i   (wr_ptr_q),
    .ld_waddr_i (ld_addr_i[ADDR_W-1:WORD_LSB]),
    .match_o    (fwd_match),
    .data_o     (fwd_data)
  );

  // Load forwarding result, qualified by the lookup strobe.
  always_comb begin
    ld_hit_o  = ld_valid_i && fwd_match;
    ld_data_o = '0;
    if (ld_hit_o) ld_data_o = fwd_data;
  end

endmodule
